// File: rtl/seg7_pkg.sv
// Shared constants, types and helpers for the 7-segment scan multiplexer.
package seg7_pkg;

    // Segment codes for hex digits 0-F: abcdefg in bits 7..1, dot (bit 0) clear.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    typedef enum logic {
        WAIT_TICK,
        PRESENT
    } scan_state_e;

    // Clock cycles per scan slot.
    function automatic int unsigned scan_period(input int unsigned clk_mhz,
                                                input int unsigned refresh_hz,
                                                input int unsigned w_digit);
        return (clk_mhz * 1_000_000) / (refresh_hz * w_digit);
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-nibble to abcdefg decoder with a blanking override.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [7:0] code;

    always_comb begin
        code = SEG_HEX[nibble];
        seg  = blank ? 7'h00 : code[7:1];
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans a packed hex value onto a multi-digit 7-segment display, one digit per slot,
// handing each digit to a downstream serializer through a valid/ready handshake.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int unsigned clk_mhz    = 100,
    parameter int unsigned w_digit    = 4,
    parameter int unsigned refresh_hz = 1000,
    parameter bit          lz_blank   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*w_digit-1:0] number,
    input  logic [w_digit-1:0]   dots,
    output logic [7:0]           abcdefgh,
    output logic [w_digit-1:0]   digit,
    output logic                 valid,
    input  logic                 ready,
    output logic                 overrun
);

    localparam int unsigned PERIOD = scan_period(clk_mhz, refresh_hz, w_digit);
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned IDX_W  = $clog2(w_digit);
    localparam int unsigned NUM_W  = 4 * w_digit;

    logic [CNT_W-1:0] cnt_q;
    logic             tick;

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_W-1:0]   snap_q, snap_d;
    logic [w_digit-1:0] dot_snap_q, dot_snap_d;
    logic [7:0]         seg_q, seg_d;
    logic [w_digit-1:0] digit_q, digit_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic               capture;
    logic [NUM_W-1:0]   cur_snap;
    logic [w_digit-1:0] cur_dots;
    logic [3:0]         nibble;
    logic               cur_dot;
    logic               upper_zero;
    logic [6:0]         dec_seg;

    assign tick = (cnt_q == CNT_W'(PERIOD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // At the index-0 tick the live inputs feed the decoder so the first digit
    // of a frame already comes from the new snapshot.
    assign capture  = (state_q == WAIT_TICK) && tick && (idx_q == '0);
    assign cur_snap = capture ? number : snap_q;
    assign cur_dots = capture ? dots : dot_snap_q;

    always_comb begin
        nibble     = '0;
        cur_dot    = 1'b0;
        upper_zero = 1'b0;
        for (int i = 0; i < int'(w_digit); i++) begin
            if (idx_q == IDX_W'(i)) begin
                nibble     = cur_snap[4*i +: 4];
                cur_dot    = cur_dots[i];
                upper_zero = (i != 0) && ((cur_snap >> (4 * i)) == '0);
            end
        end
    end

    seg7_hex_decoder u_decoder (
        .nibble (nibble),
        .blank  (lz_blank && upper_zero),
        .seg    (dec_seg)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        dot_snap_d = dot_snap_q;
        seg_d      = seg_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        // A tick while a digit is still pending is lost; remember that it happened.
        overrun_d  = overrun_q | (tick && (state_q == PRESENT));

        unique case (state_q)
            WAIT_TICK: begin
                if (tick) begin
                    if (capture) begin
                        snap_d     = number;
                        dot_snap_d = dots;
                    end
                    seg_d   = {dec_seg, cur_dot};
                    digit_d = w_digit'(1) << idx_q;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    idx_d   = (idx_q == IDX_W'(w_digit - 1)) ? '0 : idx_q + IDX_W'(1);
                    state_d = WAIT_TICK;
                end
            end
            default: state_d = WAIT_TICK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_TICK;
            idx_q      <= '0;
            snap_q     <= '0;
            dot_snap_q <= '0;
            seg_q      <= '0;
            digit_q    <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            snap_q     <= snap_d;
            dot_snap_q <= dot_snap_d;
            seg_q      <= seg_d;
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign abcdefgh = seg_q;
    assign digit    = digit_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed self-checking bench for seg7_scan_mux with a 10-cycle scan slot.
module tb_seg7_scan_mux;

    logic        clk;
    logic        rst;
    logic [15:0] number;
    logic [3:0]  dots;
    logic        ready;

    logic [7:0]  abcdefgh, abcdefgh_nb;
    logic [3:0]  digit, digit_nb;
    logic        valid, valid_nb;
    logic        overrun, overrun_nb;

    int checks = 0;
    int errors = 0;

    seg7_scan_mux #(
        .clk_mhz    (1),
        .w_digit    (4),
        .refresh_hz (25000),
        .lz_blank   (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .number   (number),
        .dots     (dots),
        .abcdefgh (abcdefgh),
        .digit    (digit),
        .valid    (valid),
        .ready    (ready),
        .overrun  (overrun)
    );

    // Same stimulus without leading-zero suppression.
    seg7_scan_mux #(
        .clk_mhz    (1),
        .w_digit    (4),
        .refresh_hz (25000),
        .lz_blank   (1'b0)
    ) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .number   (number),
        .dots     (dots),
        .abcdefgh (abcdefgh_nb),
        .digit    (digit_nb),
        .valid    (valid_nb),
        .ready    (ready),
        .overrun  (overrun_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1 ns after a rising edge; the next edge is cycle 1.
    task automatic reset_dut();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic expect_digit(input string tag, input logic [3:0] d, input logic [7:0] seg);
        check({tag, " valid"}, valid, 1);
        check({tag, " digit"}, digit, d);
        check({tag, " seg"}, abcdefgh, seg);
    endtask

    initial begin
        rst    = 1'b1;
        number = 16'h12AF;
        dots   = 4'b0000;
        ready  = 1'b1;

        // Reset state
        #3;
        check("rst abcdefgh", abcdefgh, 8'h00);
        check("rst digit", digit, 4'b0000);
        check("rst valid", valid, 0);
        check("rst overrun", overrun, 0);

        // Basic scan
        reset_dut();
        step(9);
        check("basic pre-tick valid", valid, 0);
        step(1);
        expect_digit("basic c10", 4'b0001, 8'h8E);
        step(1);
        check("basic c11 accepted", valid, 0);
        step(9);
        expect_digit("basic c20", 4'b0010, 8'hEE);
        step(10);
        expect_digit("basic c30", 4'b0100, 8'hDA);
        step(10);
        expect_digit("basic c40", 4'b1000, 8'h60);
        step(10);
        expect_digit("basic c50 wrap", 4'b0001, 8'h8E);
        check("basic overrun", overrun, 0);

        // Backpressure
        ready = 1'b0;
        reset_dut();
        step(10);
        expect_digit("bp c10", 4'b0001, 8'h8E);
        step(9);
        check("bp c19 overrun", overrun, 0);
        step(1);
        check("bp c20 overrun", overrun, 1);
        expect_digit("bp c20 hold", 4'b0001, 8'h8E);
        step(14);
        expect_digit("bp c34 hold", 4'b0001, 8'h8E);
        step(1);
        ready = 1'b1;
        step(1);
        check("bp c36 accepted", valid, 0);
        check("bp c36 digit kept", digit, 4'b0001);
        check("bp c36 seg kept", abcdefgh, 8'h8E);
        step(4);
        expect_digit("bp c40", 4'b0010, 8'hEE);
        check("bp overrun sticky", overrun, 1);

        // Reset mid-operation
        step(10);
        expect_digit("mid c50", 4'b0100, 8'hDA);
        rst = 1'b1;
        #1;
        check("async valid", valid, 0);
        check("async digit", digit, 4'b0000);
        check("async seg", abcdefgh, 8'h00);
        check("async overrun", overrun, 0);
        #1;
        rst = 1'b0;
        step(9);
        check("post-rst c9 valid", valid, 0);
        step(1);
        expect_digit("post-rst c10", 4'b0001, 8'h8E);

        // Snapshot coherence
        number = 16'h1111;
        reset_dut();
        step(10);
        expect_digit("snap c10", 4'b0001, 8'h60);
        step(10);
        expect_digit("snap c20", 4'b0010, 8'h60);
        step(5);
        number = 16'h2222;
        step(5);
        expect_digit("snap c30", 4'b0100, 8'h60);
        step(10);
        expect_digit("snap c40", 4'b1000, 8'h60);
        step(10);
        expect_digit("snap c50", 4'b0001, 8'hDA);
        step(10);
        expect_digit("snap c60", 4'b0010, 8'hDA);

        // Simultaneous tick and ready
        number = 16'h12AF;
        ready  = 1'b0;
        reset_dut();
        step(10);
        expect_digit("sim c10", 4'b0001, 8'h8E);
        step(9);
        check("sim c19 overrun", overrun, 0);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        check("sim c20 valid", valid, 0);
        check("sim c20 overrun", overrun, 1);
        check("sim c20 digit", digit, 4'b0001);
        step(9);
        check("sim c29 valid", valid, 0);
        step(1);
        expect_digit("sim c30", 4'b0010, 8'hEE);

        // Dots and leading-zero blanking
        number = 16'h0050;
        dots   = 4'b0100;
        ready  = 1'b1;
        reset_dut();
        step(10);
        expect_digit("lz d0", 4'b0001, 8'hFC);
        check("nb d0", abcdefgh_nb, 8'hFC);
        step(10);
        expect_digit("lz d1", 4'b0010, 8'hB6);
        check("nb d1", abcdefgh_nb, 8'hB6);
        step(10);
        expect_digit("lz d2", 4'b0100, 8'h01);
        check("nb d2", abcdefgh_nb, 8'hFD);
        step(10);
        expect_digit("lz d3", 4'b1000, 8'h00);
        check("nb d3", abcdefgh_nb, 8'hFC);
        check("lz overrun", overrun, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
